// File: rtl/memctrl_host_if.sv
// Host-side access sequencer for MEMCTRL: turns single/burst valid/ready requests
// into per-beat CE/CSB/WEB/OEB strobe sequences and returns read data as response pulses.
module memctrl_host_if #(
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [15:0] i_req_addr,
  input  logic [7:0]  i_req_len,
  input  logic [7:0]  i_req_wdata,
  input  logic        i_req_winc,
  input  logic        i_bist_busy,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_rdata,
  output logic        o_done,
  output logic [15:0] o_m_addr,
  output logic        o_m_ce,
  output logic        o_m_csb,
  output logic        o_m_web,
  output logic        o_m_oeb,
  output logic [7:0]  o_m_idata,
  input  logic [7:0]  i_m_odata,
  output logic [2:0]  o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_REC    = 3'd5;
  localparam logic [2:0] S_PAUSE  = 3'd6;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  // Handshake: a request is taken on a rising edge where i_req_valid and
  // o_req_ready are both high; o_req_ready is only ever high in IDLE.

  logic [2:0] r_state;
  logic       r_we;
  logic       r_winc;
  logic [7:0] r_cnt;   // beats remaining, 0 encodes 256
  logic [7:0] r_data;
  logic [1:0] r_wait;
  logic [7:0] w_next_data;

  assign w_next_data = r_winc ? r_data + 8'd1 : r_data;
  assign o_state     = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_winc      <= 1'b0;
      r_cnt       <= 8'd0;
      r_data      <= 8'd0;
      r_wait      <= 2'd0;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 8'd0;
      o_done      <= 1'b0;
      o_m_addr    <= 16'd0;
      o_m_ce      <= 1'b0;
      o_m_csb     <= 1'b1;
      o_m_web     <= 1'b1;
      o_m_oeb     <= 1'b1;
      o_m_idata   <= 8'd0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_req_ready <= ~i_bist_busy;
          if (o_req_ready && i_req_valid) begin
            r_we        <= i_req_we;
            r_winc      <= i_req_winc;
            r_cnt       <= i_req_len;
            r_data      <= i_req_wdata;
            o_m_addr    <= i_req_addr;
            o_m_ce      <= 1'b1;
            o_m_idata   <= i_req_we ? i_req_wdata : 8'd0;
            o_req_ready <= 1'b0;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          o_m_csb <= 1'b0;
          o_m_web <= ~r_we;
          o_m_oeb <= r_we;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          o_m_ce <= 1'b0;
          if (r_we) begin
            r_state <= S_HOLD;
          end else begin
            r_wait  <= WAIT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_HOLD: begin
          o_m_csb   <= 1'b1;
          o_m_web   <= 1'b1;
          o_m_idata <= 8'd0;
          r_state   <= S_REC;
        end
        S_WAIT: begin
          // ODATA is captured on the edge that closes the last wait cycle.
          if (r_wait == 2'd0) begin
            o_m_csb     <= 1'b1;
            o_m_oeb     <= 1'b1;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= i_m_odata;
            r_state     <= S_REC;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        S_REC: begin
          o_m_addr <= o_m_addr + 16'd1;
          r_data   <= w_next_data;
          if (r_cnt == 8'd1) begin
            o_done      <= 1'b1;
            o_req_ready <= ~i_bist_busy;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
            if (i_bist_busy) begin
              r_state <= S_PAUSE;
            end else begin
              o_m_ce    <= 1'b1;
              o_m_idata <= r_we ? w_next_data : 8'd0;
              r_state   <= S_SETUP;
            end
          end
        end
        S_PAUSE: begin
          if (!i_bist_busy) begin
            o_m_ce    <= 1'b1;
            o_m_idata <= r_we ? r_data : 8'd0;
            r_state   <= S_SETUP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memctrl_host_if.sv
// Directed bench for memctrl_host_if with a behavioural MEMCTRL byte array
// and immediate-assertion checks against hand-computed expectations.
module tb_memctrl_host_if;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_len;
  logic [7:0]  req_wdata;
  logic        req_winc;
  logic        bist_busy;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        done;
  logic [15:0] m_addr;
  logic        m_ce;
  logic        m_csb;
  logic        m_web;
  logic        m_oeb;
  logic [7:0]  m_idata;
  logic [7:0]  m_odata;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int ready_hi;
  logic [7:0]  exp_q[$];
  logic [7:0]  rsp_q[$];
  int          rsp_cyc_q[$];
  logic [15:0] setup_addr_q[$];
  logic [7:0]  mem [0:65535];

  memctrl_host_if #(.RD_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_len(req_len),
    .i_req_wdata(req_wdata), .i_req_winc(req_winc),
    .i_bist_busy(bist_busy),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_done(done),
    .o_m_addr(m_addr), .o_m_ce(m_ce), .o_m_csb(m_csb), .o_m_web(m_web),
    .o_m_oeb(m_oeb), .o_m_idata(m_idata), .i_m_odata(m_odata),
    .o_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MEMCTRL model: write while CSB/WEB low, read data presented while CSB/OEB low
  always @(posedge clk) begin
    if (!m_csb && !m_web) mem[m_addr] <= m_idata;
  end
  assign m_odata = (!m_csb && !m_oeb) ? mem[m_addr] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present a request, take it on the next edge, SETUP is then visible
  task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] len,
                       input logic [7:0] wdata, input logic winc);
    rsp_q.delete();
    rsp_cyc_q.delete();
    setup_addr_q.delete();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wdata;
    req_winc  = winc;
    step();
    req_valid = 1'b0;
    req_addr  = 16'hDEAD;
    req_wdata = 8'hEE;
    cyc       = 0;
    ready_hi  = 0;
  endtask

  task automatic run_to_done(input string tag, input int limit);
    while (cyc < limit) begin
      if (m_ce && m_csb) setup_addr_q.push_back(m_addr);
      if (rsp_valid) begin
        rsp_q.push_back(rsp_rdata);
        rsp_cyc_q.push_back(cyc);
      end
      if (done) break;
      if (req_ready) ready_hi++;
      step();
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_ready_low"}, ready_hi, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0;
    req_len = 8'd0; req_wdata = 8'h0; req_winc = 1'b0; bist_busy = 1'b0;
    repeat (3) step();

    // reset values
    check("rst_ready", req_ready, 1'b0);
    check("rst_rsp", {rsp_valid, rsp_rdata, done}, 10'h0);
    check("rst_m_addr", m_addr, 16'h0);
    check("rst_strobes", {m_ce, m_csb, m_web, m_oeb}, 4'b0111);
    check("rst_idata", m_idata, 8'h0);
    rst_n = 1'b1;
    step();
    check("rel_ready", req_ready, 1'b1);

    // single write, per-cycle strobe sequence
    issue(1'b1, 16'h0010, 8'd1, 8'hA5, 1'b0);
    check("w1_setup", {m_ce, m_csb, m_web, m_oeb}, 4'b1111);
    check("w1_setup_data", m_idata, 8'hA5);
    check("w1_setup_addr", m_addr, 16'h0010);
    check("w1_setup_ready", req_ready, 1'b0);
    step();
    check("w1_strobe", {m_ce, m_csb, m_web, m_oeb}, 4'b1001);
    check("w1_strobe_data", m_idata, 8'hA5);
    step();
    check("w1_hold", {m_ce, m_csb, m_web}, 3'b000);
    check("w1_hold_addr", m_addr, 16'h0010);
    step();
    check("w1_rec", {m_ce, m_csb, m_web, done}, 4'b0110);
    check("w1_rec_data", m_idata, 8'h00);
    step();
    check("w1_done", {done, req_ready}, 2'b11);
    check("w1_next_addr", m_addr, 16'h0011);
    check("w1_mem", mem[16'h0010], 8'hA5);
    step();
    check("w1_done_pulse", done, 1'b0);

    // burst write with increment
    issue(1'b1, 16'h0100, 8'd4, 8'h10, 1'b1);
    run_to_done("w4", 200);
    check("w4_cycles", cyc, 16);
    check("w4_mem3", mem[16'h0103], 8'h13);

    // burst read back, four pulses spaced four cycles apart
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    issue(1'b0, 16'h0100, 8'd4, 8'h00, 1'b0);
    run_to_done("r4", 200);
    check("r4_cycles", cyc, 16);
    check("r4_count", rsp_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < rsp_q.size()) begin
        check($sformatf("r4_data%0d", k), rsp_q[k], exp_q[k]);
        check($sformatf("r4_cyc%0d", k), rsp_cyc_q[k], 3 + 4 * k);
      end
    end

    // LEN=0 means 256 beats, address wraps through 0000
    issue(1'b0, 16'hFFFE, 8'd0, 8'h00, 1'b0);
    run_to_done("wrap", 2000);
    check("wrap_cycles", cyc, 1024);
    check("wrap_rsp_count", rsp_q.size(), 256);
    check("wrap_setup_count", setup_addr_q.size(), 256);
    if (setup_addr_q.size() == 256) begin
      check("wrap_a0", setup_addr_q[0], 16'hFFFE);
      check("wrap_a1", setup_addr_q[1], 16'hFFFF);
      check("wrap_a2", setup_addr_q[2], 16'h0000);
      check("wrap_a255", setup_addr_q[255], 16'h00FD);
    end
    step();
    check("wrap_single_done", done, 1'b0);

    // BIST raised in STROBE of the second beat
    issue(1'b1, 16'h0200, 8'd4, 8'h20, 1'b0);
    repeat (5) step();
    check("bist_strobe", {m_ce, m_csb, m_web}, 3'b100);
    check("bist_strobe_addr", m_addr, 16'h0201);
    bist_busy = 1'b1;
    step();
    check("bist_hold_kept", {m_csb, m_web}, 2'b00);
    step();
    check("bist_rec", {m_csb, m_web}, 2'b11);
    for (int p = 0; p < 3; p++) begin
      step();
      check($sformatf("bist_pause%0d", p), {m_ce, m_csb, m_web, m_oeb}, 4'b0111);
      check($sformatf("bist_pause_addr%0d", p), m_addr, 16'h0202);
      check($sformatf("bist_pause_ready%0d", p), req_ready, 1'b0);
    end
    bist_busy = 1'b0;
    step();
    check("bist_resume", {m_ce, m_csb}, 2'b11);
    check("bist_resume_addr", m_addr, 16'h0202);
    check("bist_resume_data", m_idata, 8'h20);
    cyc = 11;
    run_to_done("bist", 200);
    check("bist_cycles", cyc, 19);
    check("bist_mem3", mem[16'h0203], 8'h20);

    // asynchronous reset during HOLD of the first beat
    step();
    issue(1'b1, 16'h0300, 8'd4, 8'h55, 1'b0);
    repeat (2) step();
    check("rm_hold", {m_csb, m_web}, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check("rm_async", {m_ce, m_csb, m_web, m_oeb}, 4'b0111);
    check("rm_async_addr", m_addr, 16'h0000);
    ready_hi = 0;
    for (int p = 0; p < 3; p++) begin
      step();
      if (done) ready_hi++;
    end
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      step();
      if (done) ready_hi++;
    end
    check("rm_no_done", ready_hi, 0);
    check("rm_ready", req_ready, 1'b1);
    issue(1'b0, 16'h0010, 8'd1, 8'h00, 1'b0);
    run_to_done("rm_read", 100);
    check("rm_read_cycles", cyc, 4);
    check("rm_read_count", rsp_q.size(), 1);
    if (rsp_q.size() == 1) check("rm_read_data", rsp_q[0], 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
